// File: rtl/id_ex_reg_pkg.sv
// Shared decode/execute definitions for the PCPU pipeline: control-field
// widths, register-index width, datapath width and the NOP instruction word
// that fills empty pipeline slots.
package id_ex_reg_pkg;

  localparam int C_XLEN     = 32;
  localparam int C_RIDX_W   = 5;
  localparam int C_ALUOP_W  = 5;
  localparam int NPCOP_W    = 5;
  localparam int WDSEL_W    = 2;
  localparam int DMTYPE_W   = 3;

  // addi x0,x0,0
  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

  // Write-back source encodings carried in WDSel.
  typedef enum logic [WDSEL_W-1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2
  } wdsel_e;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with synchronous reset, synchronous clear to a
// constant value, and an active-low load enable (en_n=1 holds).
// Priority on each edge: rst > clr > hold > load.
module pipe_reg_en_clr #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Reset/clear to the constant, otherwise hold or load.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= RST_VAL;
    end else if (!en_n) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures operands, register indices and the
// decoded control bundle at the end of ID. Flush loads a bubble (valid=0,
// controls/indices/data zero, instr=NOP) and wins over stall. An invalid ID
// slot loads the same bubble contents except pc/instr pass through.
// RegWrite is masked when rd is x0 so x0 writes never reach write-back.
// Optional build macro ID_EX_PERF_EN adds saturating bubble/stall counters.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int          XLEN      = C_XLEN,
  parameter int          RIDX_W    = C_RIDX_W,
  parameter int          ALUOP_W   = C_ALUOP_W,
  parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_E,
  input  logic                flush_E,
  input  logic                valid_D,
  input  logic [XLEN-1:0]     pc_D,
  input  logic [31:0]         instr_D,
  input  logic [XLEN-1:0]     rd1_D,
  input  logic [XLEN-1:0]     rd2_D,
  input  logic [XLEN-1:0]     immout_D,
  input  logic [RIDX_W-1:0]   rs1_D,
  input  logic [RIDX_W-1:0]   rs2_D,
  input  logic [RIDX_W-1:0]   rd_D,
  input  logic                RegWrite_D,
  input  logic                MemWrite_D,
  input  logic                MemRead_D,
  input  logic                ALUSrc_D,
  input  logic [ALUOP_W-1:0]  ALUOp_D,
  input  logic [NPCOP_W-1:0]  NPCOp_D,
  input  logic [WDSEL_W-1:0]  WDSel_D,
  input  logic [DMTYPE_W-1:0] DMType_D,
  output logic                valid_E,
  output logic [XLEN-1:0]     pc_E,
  output logic [31:0]         instr_E,
  output logic [XLEN-1:0]     rd1_E,
  output logic [XLEN-1:0]     rd2_E,
  output logic [XLEN-1:0]     immout_E,
  output logic [RIDX_W-1:0]   rs1_E,
  output logic [RIDX_W-1:0]   rs2_E,
  output logic [RIDX_W-1:0]   rd_E,
  output logic                RegWrite_E,
  output logic                MemWrite_E,
  output logic                MemRead_E,
  output logic                ALUSrc_E,
  output logic [ALUOP_W-1:0]  ALUOp_E,
  output logic [NPCOP_W-1:0]  NPCOp_E,
  output logic [WDSEL_W-1:0]  WDSel_E,
  output logic [DMTYPE_W-1:0] DMType_E
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         bubble_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int DATA_W = 4 * XLEN + 32;
  localparam int IDX_W  = 3 * RIDX_W;
  localparam int CTRL_W = 5 + ALUOP_W + NPCOP_W + WDSEL_W + DMTYPE_W;

  // Bubble contents for the data group: everything zero except the NOP word.
  localparam logic [DATA_W-1:0] DATA_RST = {{XLEN{1'b0}}, NOP_INSTR, {(3*XLEN){1'b0}}};

  logic [DATA_W-1:0] w_data_d, w_data_q;
  logic [IDX_W-1:0]  w_idx_d,  w_idx_q;
  logic [CTRL_W-1:0] w_ctrl_d, w_ctrl_q;
  logic              w_regwrite_m;

  // An invalid slot carries pc/instr for debug but nothing that could act.
  assign w_regwrite_m = RegWrite_D && (rd_D != '0);
  assign w_data_d = valid_D ? {pc_D, instr_D, rd1_D, rd2_D, immout_D}
                            : {pc_D, instr_D, {(3*XLEN){1'b0}}};
  assign w_idx_d  = valid_D ? {rs1_D, rs2_D, rd_D} : '0;
  assign w_ctrl_d = valid_D ? {1'b1, w_regwrite_m, MemWrite_D, MemRead_D, ALUSrc_D,
                               ALUOp_D, NPCOp_D, WDSel_D, DMType_D}
                            : '0;

  pipe_reg_en_clr #(.W(DATA_W), .RST_VAL(DATA_RST)) u_data (
    .clk (clk), .rst (rst), .clr (flush_E), .en_n (stall_E),
    .d   (w_data_d), .q (w_data_q)
  );

  pipe_reg_en_clr #(.W(IDX_W), .RST_VAL('0)) u_idx (
    .clk (clk), .rst (rst), .clr (flush_E), .en_n (stall_E),
    .d   (w_idx_d), .q (w_idx_q)
  );

  pipe_reg_en_clr #(.W(CTRL_W), .RST_VAL('0)) u_ctrl (
    .clk (clk), .rst (rst), .clr (flush_E), .en_n (stall_E),
    .d   (w_ctrl_d), .q (w_ctrl_q)
  );

  assign {pc_E, instr_E, rd1_E, rd2_E, immout_E} = w_data_q;
  assign {rs1_E, rs2_E, rd_E}                    = w_idx_q;
  assign {valid_E, RegWrite_E, MemWrite_E, MemRead_E, ALUSrc_E,
          ALUOp_E, NPCOp_E, WDSel_E, DMType_E}   = w_ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_bubble_inc;
  logic        w_stall_inc;

  assign w_bubble_inc = flush_E || (!stall_E && !valid_D);
  assign w_stall_inc  = stall_E && !flush_E;

  // Saturating counters of bubbles loaded and stall cycles held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bubble_inc && (r_bubble_cnt != 32'hFFFF_FFFF)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall_inc  && (r_stall_cnt  != 32'hFFFF_FFFF)) r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, pass-through, stall hold, flush vs
// stall priority, x0 write masking, invalid-slot load and reset mid-stall.
// Counter checks are included when ID_EX_PERF_EN is defined.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, stall_E, flush_E, valid_D;
  logic [31:0] pc_D, instr_D, rd1_D, rd2_D, immout_D;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic        RegWrite_D, MemWrite_D, MemRead_D, ALUSrc_D;
  logic [4:0]  ALUOp_D, NPCOp_D;
  logic [1:0]  WDSel_D;
  logic [2:0]  DMType_D;

  logic        valid_E;
  logic [31:0] pc_E, instr_E, rd1_E, rd2_E, immout_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
  logic        RegWrite_E, MemWrite_E, MemRead_E, ALUSrc_E;
  logic [4:0]  ALUOp_E, NPCOp_E;
  logic [1:0]  WDSel_E;
  logic [2:0]  DMType_E;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk (clk), .rst (rst), .stall_E (stall_E), .flush_E (flush_E),
    .valid_D (valid_D), .pc_D (pc_D), .instr_D (instr_D),
    .rd1_D (rd1_D), .rd2_D (rd2_D), .immout_D (immout_D),
    .rs1_D (rs1_D), .rs2_D (rs2_D), .rd_D (rd_D),
    .RegWrite_D (RegWrite_D), .MemWrite_D (MemWrite_D),
    .MemRead_D (MemRead_D), .ALUSrc_D (ALUSrc_D),
    .ALUOp_D (ALUOp_D), .NPCOp_D (NPCOp_D), .WDSel_D (WDSel_D),
    .DMType_D (DMType_D),
    .valid_E (valid_E), .pc_E (pc_E), .instr_E (instr_E),
    .rd1_E (rd1_E), .rd2_E (rd2_E), .immout_E (immout_E),
    .rs1_E (rs1_E), .rs2_E (rs2_E), .rd_E (rd_E),
    .RegWrite_E (RegWrite_E), .MemWrite_E (MemWrite_E),
    .MemRead_E (MemRead_E), .ALUSrc_E (ALUSrc_E),
    .ALUOp_E (ALUOp_E), .NPCOp_E (NPCOp_E), .WDSel_E (WDSel_E),
    .DMType_E (DMType_E)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_cnt (bubble_cnt), .stall_cnt (stall_cnt)
`endif
  );

  // Driver: advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [31:0] v);
    valid_D = v[0]; pc_D = v; instr_D = v; rd1_D = v; rd2_D = v; immout_D = v;
    rs1_D = v[4:0]; rs2_D = v[4:0]; rd_D = v[4:0];
    RegWrite_D = v[0]; MemWrite_D = v[0]; MemRead_D = v[0]; ALUSrc_D = v[0];
    ALUOp_D = v[4:0]; NPCOp_D = v[4:0]; WDSel_D = v[1:0]; DMType_D = v[2:0];
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall_E = 1'b0; flush_E = 1'b0;
    drive_all(32'hFFFF_FFFF);
    step();
    step();
    check("rst_valid",    {31'd0, valid_E},    32'd0);
    check("rst_instr",    instr_E,             32'h0000_0013);
    check("rst_regwrite", {31'd0, RegWrite_E}, 32'd0);
    check("rst_immout",   immout_E,            32'd0);
    check("rst_pc",       pc_E,                32'd0);
    check("rst_rd",       {27'd0, rd_E},       32'd0);
`ifdef ID_EX_PERF_EN
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
    check("rst_stall_cnt",  stall_cnt,  32'd0);
`endif

    // Pass-through of a valid instruction
    rst = 1'b0;
    drive_all(32'd0);
    valid_D = 1'b1; pc_D = 32'h0000_0100; instr_D = 32'h00A0_0293;
    immout_D = 32'hFFFF_F800; rd1_D = 32'h1234_5678; rd2_D = 32'h9ABC_DEF0;
    rs1_D = 5'd3; rs2_D = 5'd4; rd_D = 5'd5; RegWrite_D = 1'b1; ALUSrc_D = 1'b1;
    ALUOp_D = 5'd9; NPCOp_D = 5'd2; WDSel_D = 2'd1; DMType_D = 3'd4;
    step();
    check("pt_immout",   immout_E,            32'hFFFF_F800);
    check("pt_rd",       {27'd0, rd_E},       32'd5);
    check("pt_regwrite", {31'd0, RegWrite_E}, 32'd1);
    check("pt_valid",    {31'd0, valid_E},    32'd1);
    check("pt_pc",       pc_E,                32'h0000_0100);
    check("pt_instr",    instr_E,             32'h00A0_0293);
    check("pt_rd1",      rd1_E,               32'h1234_5678);
    check("pt_rd2",      rd2_E,               32'h9ABC_DEF0);
    check("pt_rs1_rs2",  {22'd0, rs1_E, rs2_E}, {22'd0, 5'd3, 5'd4});
    check("pt_ctrl",     {13'd0, ALUSrc_E, ALUOp_E, NPCOp_E, WDSel_E, DMType_E},
                         {13'd0, 1'b1, 5'd9, 5'd2, 2'd1, 3'd4});

    // Stall hold for three cycles, then release
    pc_D = 32'h0000_0040;
    step();
    check("st_load_pc", pc_E, 32'h0000_0040);
    stall_E = 1'b1; pc_D = 32'h0000_0044;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_0040);
    exp_q.push_back(32'h0000_0044);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_E = 1'b0;
      step();
      check($sformatf("st_pc_%0d", i), pc_E, exp_q.pop_front());
    end
`ifdef ID_EX_PERF_EN
    check("st_stall_cnt", stall_cnt, 32'd3);
`endif

    // Flush and stall together: flush wins
    stall_E = 1'b1; flush_E = 1'b1; MemWrite_D = 1'b1;
    step();
    check("fl_memwrite", {31'd0, MemWrite_E}, 32'd0);
    check("fl_valid",    {31'd0, valid_E},    32'd0);
    check("fl_instr",    instr_E,             32'h0000_0013);
    check("fl_pc",       pc_E,                32'd0);
    check("fl_idx",      {17'd0, rs1_E, rs2_E, rd_E}, 32'd0);
    check("fl_data",     rd1_E | rd2_E | immout_E, 32'd0);
    check("fl_ctrl",     {12'd0, RegWrite_E, MemRead_E, ALUSrc_E, ALUOp_E, NPCOp_E, WDSel_E, DMType_E}, 32'd0);

    // Second flush on its own
    stall_E = 1'b0;
    step();
    check("fl2_valid", {31'd0, valid_E}, 32'd0);
`ifdef ID_EX_PERF_EN
    check("fl_bubble_cnt", bubble_cnt, 32'd2);
    check("fl_stall_cnt",  stall_cnt,  32'd3);
`endif

    // Write to x0 is masked
    flush_E = 1'b0; MemWrite_D = 1'b0;
    valid_D = 1'b1; rd_D = 5'd0; RegWrite_D = 1'b1; MemRead_D = 1'b1;
    step();
    check("x0_regwrite", {31'd0, RegWrite_E}, 32'd0);
    check("x0_rd",       {27'd0, rd_E},       32'd0);
    check("x0_memread",  {31'd0, MemRead_E},  32'd1);
    check("x0_valid",    {31'd0, valid_E},    32'd1);

    // Invalid ID slot: bubble contents, pc/instr pass through
    valid_D = 1'b0; pc_D = 32'h0000_0080; instr_D = 32'h1234_5678;
    rd_D = 5'd7; RegWrite_D = 1'b1; immout_D = 32'd5;
    step();
    check("inv_valid",    {31'd0, valid_E},    32'd0);
    check("inv_regwrite", {31'd0, RegWrite_E}, 32'd0);
    check("inv_memread",  {31'd0, MemRead_E},  32'd0);
    check("inv_rd",       {27'd0, rd_E},       32'd0);
    check("inv_pc",       pc_E,                32'h0000_0080);
    check("inv_instr",    instr_E,             32'h1234_5678);
    check("inv_immout",   immout_E,            32'd0);
`ifdef ID_EX_PERF_EN
    check("inv_bubble_cnt", bubble_cnt, 32'd3);
    check("inv_stall_cnt",  stall_cnt,  32'd3);
`endif

    // Reset while stalling
    valid_D = 1'b1; rd_D = 5'd9; stall_E = 1'b1; rst = 1'b1;
    step();
    check("rs_instr", instr_E,          32'h0000_0013);
    check("rs_pc",    pc_E,             32'd0);
    check("rs_valid", {31'd0, valid_E}, 32'd0);
`ifdef ID_EX_PERF_EN
    check("rs_bubble_cnt", bubble_cnt, 32'd0);
    check("rs_stall_cnt",  stall_cnt,  32'd0);
`endif

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the PCPU.
- Captures the sign-extended immediate from the immediate extender, the register-file read data, the register indices and the decoded control bundle at the end of ID, and presents them to EX one cycle later.
- Implements hazard-unit stall (hold) and flush (bubble injection).
- Carries a valid bit so EX/MEM/WB and the forwarding logic ignore bubbles.

Parameters:
- XLEN, 32, datapath and immediate width
- RIDX_W, 5, register index width
- ALUOP_W, 5, ALU operation code width
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) loaded on reset/flush

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- stall_E  input  1  hold all E-side registers this cycle
- flush_E  input  1  load a bubble this cycle
- valid_D  input  1  ID slot holds a real instruction
- pc_D  input  XLEN  PC of ID instruction
- instr_D  input  32  ID instruction word
- rd1_D, rd2_D  input  XLEN  register-file read data
- immout_D  input  XLEN  immediate-extender output
- rs1_D, rs2_D, rd_D  input  RIDX_W  register indices
- RegWrite_D, MemWrite_D, MemRead_D, ALUSrc_D  input  1  control bits
- ALUOp_D  input  ALUOP_W  ALU op
- NPCOp_D  input  5  next-PC op
- WDSel_D  input  2  write-back select
- DMType_D  input  3  load/store width/sign
- *_E outputs  output  same widths  registered copies of every *_D input above, including valid_E

Behaviour:
- Single register stage; latency exactly 1 cycle, no combinational path from input to output.
- Priority per rising edge: rst > flush_E > stall_E > normal load.
- rst=1:
  - all outputs 0 except instr_E=NOP_INSTR.
  - valid_E=0; RegWrite_E=MemWrite_E=MemRead_E=0.
- flush_E=1 (rst=0), bubble:
  - valid_E=0; all control outputs 0.
  - rd_E=0; rs1_E=rs2_E=0, so the forwarding unit never matches a bubble.
  - instr_E=NOP_INSTR; pc_E, rd1_E, rd2_E, immout_E = 0.
  - Flush wins over a simultaneous stall_E; the bubble is loaded regardless of stall.
- stall_E=1 (rst=0, flush_E=0): every output holds its previous value. Holding for N consecutive cycles is allowed, unbounded.
- Normal (rst=flush_E=stall_E=0):
  - every *_E <= *_D.
  - If valid_D=0, the stage still loads, but control outputs are forced to 0 and rd_E to 0, i.e. identical to a bubble except pc_E/instr_E pass through.
- Write-enable masking: RegWrite_E is forced 0 whenever rd_D=0 at load time, so x0 writes never propagate.
- immout_E is a plain XLEN copy with no re-extension; width is fixed at XLEN.
- Reset asserted mid-stall or mid-flush: reset result next edge, counters cleared (see feature).

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined:
  - adds outputs bubble_cnt (32) and stall_cnt (32).
  - bubble_cnt increments on each edge where flush_E=1, or a normal load with valid_D=0.
  - stall_cnt increments on each edge with stall_E=1 and flush_E=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared defines header (alongside the existing control-encode definitions):
  - NOP instruction constant
  - ALUOP/NPCOp/WDSel/DMType widths
  - register-index width
- One natural sub-module: pipe_reg_en_clr. It is a parameterised width register with rst, clr (loads a parameter reset value), and en_n (hold). Instantiate once per field group: data, indices, control.
- Bubble forcing and RegWrite masking stay in id_ex_reg.

Test Plan:
- Reset: rst=1 two cycles, all D inputs 1s → after edge valid_E=0, instr_E=32'h00000013, RegWrite_E=0, immout_E=0.
- Pass-through: immout_D=32'hFFFF_F800, rd_D=5, RegWrite_D=1, valid_D=1 → next cycle immout_E=32'hFFFF_F800, rd_E=5, RegWrite_E=1, valid_E=1.
- Stall hold: load pc_D=32'h0000_0040, then stall_E=1 for 3 cycles with pc_D=32'h0000_0044 → pc_E stays 32'h0000_0040 for 3 cycles, becomes 32'h0000_0044 after release.
- Flush+stall same cycle: stall_E=1, flush_E=1, MemWrite_D=1 → MemWrite_E=0, valid_E=0, instr_E=NOP; flush priority confirmed.
- x0 masking: rd_D=0, RegWrite_D=1, valid_D=1 → RegWrite_E=0, rd_E=0.
- ID_EX_PERF_EN: 2 flushes + 3 stalls + 1 valid_D=0 load → bubble_cnt=3, stall_cnt=3; rst clears both to 0.
